// File: rtl/three_bit.sv
// Registered 3-bit ripple-carry adder with carry out and a valid flag.
// Optional carry-in port enabled by defining THREE_BIT_CIN_EN.
module three_bit (
   input  logic clk,
   input  logic rst,
   input  logic a0,
   input  logic a1,
   input  logic a2,
   input  logic b0,
   input  logic b1,
   input  logic b2,
   input  logic in_valid,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic cout,
   output logic out_valid
`ifdef THREE_BIT_CIN_EN
   ,
   input  logic cin
`endif
);

   logic c0, c1, c2, c3;
   logic sum0, sum1, sum2;

`ifdef THREE_BIT_CIN_EN
   assign c0 = cin;
`else
   assign c0 = 1'b0;
`endif

   // Three full-adder cells in ripple; each carry feeds the next stage.
   assign sum0 = a0 ^ b0 ^ c0;
   assign c1   = (a0 & b0) | (a0 & c0) | (b0 & c0);
   assign sum1 = a1 ^ b1 ^ c1;
   assign c2   = (a1 & b1) | (a1 & c1) | (b1 & c1);
   assign sum2 = a2 ^ b2 ^ c2;
   assign c3   = (a2 & b2) | (a2 & c2) | (b2 & c2);

   always_ff @(posedge clk) begin
      if (rst) begin
         s0        <= 1'b0;
         s1        <= 1'b0;
         s2        <= 1'b0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         // Result bits hold their last value when no new operands arrive.
         if (in_valid) begin
            s0   <= sum0;
            s1   <= sum1;
            s2   <= sum2;
            cout <= c3;
         end
      end
   end

endmodule

// File: tb/tb_three_bit.sv
// Self-checking bench for three_bit: directed cases, exhaustive sweep and random traffic
// against an arithmetic reference model.
module tb_three_bit;

`ifdef THREE_BIT_CIN_EN
   localparam bit CIN_EN = 1'b1;
`else
   localparam bit CIN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic a0, a1, a2, b0, b1, b2, in_valid, cin;
   logic s0, s1, s2, cout, out_valid;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_res;
   logic       exp_valid;

   always #5 clk = ~clk;

   three_bit dut (
      .clk(clk), .rst(rst),
      .a0(a0), .a1(a1), .a2(a2),
      .b0(b0), .b1(b1), .b2(b2),
      .in_valid(in_valid),
      .s0(s0), .s1(s1), .s2(s2),
      .cout(cout), .out_valid(out_valid)
`ifdef THREE_BIT_CIN_EN
      , .cin(cin)
`endif
   );

   // Drive one cycle of stimulus, clock it, and advance the reference model.
   task automatic step(input bit r, input int a, input int b, input bit ci, input bit v);
      int av, bv;
      bit cv;
      logic [2:0] ab, bb;
      av = a % 8;
      bv = b % 8;
      cv = CIN_EN ? ci : 1'b0;
      ab = 3'(av);
      bb = 3'(bv);
      rst = r;
      in_valid = v;
      {a2, a1, a0} = ab;
      {b2, b1, b0} = bb;
      cin = cv;
      @(posedge clk);
      #1;
      if (r) begin
         exp_res = 4'd0;
         exp_valid = 1'b0;
      end else begin
         exp_valid = v;
         if (v) exp_res = 4'(av + bv + int'(cv));
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, int'($urandom_range(7)), int'($urandom_range(7)), 1'($urandom), 1'b1);
         checks++;
         if ({cout, s2, s1, s0} !== 4'd0) begin
            errors++;
            $display("FAIL reset_result got %b want 0000", {cout, s2, s1, s0});
         end
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", out_valid);
         end
      end
   endtask

   task automatic test_directed();
      int ta[2] = '{2, 3};
      int tb[2] = '{2, 7};
      logic [3:0] want[2] = '{4'd4, 4'd10};
      for (int i = 0; i < 2; i++) begin
         step(1'b0, ta[i], tb[i], 1'b0, 1'b1);
         checks++;
         if ({cout, s2, s1, s0} !== want[i] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL directed_%0d got res=%0d v=%b want res=%0d v=1",
                     i, {cout, s2, s1, s0}, out_valid, want[i]);
         end
      end
   endtask

   task automatic test_hold();
      step(1'b0, 5, 1, 1'b0, 1'b1);
      checks++;
      if ({cout, s2, s1, s0} !== 4'd6 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_load got res=%0d v=%b want res=6 v=1", {cout, s2, s1, s0}, out_valid);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, int'($urandom_range(7)), int'($urandom_range(7)), 1'($urandom), 1'b0);
         checks++;
         if ({cout, s2, s1, s0} !== 4'd6 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle_%0d got res=%0d v=%b want res=6 v=0",
                     i, {cout, s2, s1, s0}, out_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      step(1'b0, 7, 7, 1'b0, 1'b1);
      checks++;
      if ({cout, s2, s1, s0} !== 4'd14 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first got res=%0d v=%b want res=14 v=1", {cout, s2, s1, s0}, out_valid);
      end
      step(1'b0, 0, 0, 1'b0, 1'b1);
      checks++;
      if ({cout, s2, s1, s0} !== 4'd0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second got res=%0d v=%b want res=0 v=1", {cout, s2, s1, s0}, out_valid);
      end
      if (CIN_EN) begin
         step(1'b0, 7, 7, 1'b1, 1'b1);
         checks++;
         if ({cout, s2, s1, s0} !== 4'd15) begin
            errors++;
            $display("FAIL b2b_cin got res=%0d want res=15", {cout, s2, s1, s0});
         end
      end
   endtask

   task automatic test_sweep();
      int n = 0;
      for (int c = 0; c < (CIN_EN ? 2 : 1); c++) begin
         for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
               if (n == 37) begin
                  step(1'b1, a, b, 1'(c), 1'b1);
                  checks++;
                  if ({cout, s2, s1, s0} !== 4'd0 || out_valid !== 1'b0) begin
                     errors++;
                     $display("FAIL sweep_reset got res=%0d v=%b want res=0 v=0",
                              {cout, s2, s1, s0}, out_valid);
                  end
               end
               n++;
               step(1'b0, a, b, 1'(c), 1'b1);
               checks++;
               if ({cout, s2, s1, s0} !== 4'(a + b + c) || out_valid !== 1'b1) begin
                  errors++;
                  $display("FAIL sweep a=%0d b=%0d c=%0d got res=%0d v=%b want res=%0d v=1",
                           a, b, c, {cout, s2, s1, s0}, out_valid, a + b + c);
               end
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(19) == 0, int'($urandom_range(7)), int'($urandom_range(7)),
              1'($urandom), 1'($urandom));
         checks++;
         if ({cout, s2, s1, s0} !== exp_res || out_valid !== exp_valid) begin
            errors++;
            $display("FAIL random_%0d got res=%0d v=%b want res=%0d v=%b",
                     i, {cout, s2, s1, s0}, out_valid, exp_res, exp_valid);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      {a2, a1, a0} = 3'd0;
      {b2, b1, b0} = 3'd0;
      cin = 1'b0;
      exp_res = 4'd0;
      exp_valid = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_directed();
      test_hold();
      test_back_to_back();
      test_sweep();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
